et_chord_sequencer: RTL
=======================

Name: et_chord_sequencer

Overview:
- Ear Training playback sequencer; sits directly upstream of the per-voice freq_pwm tone generators in the piano/software-control top level.
- On a start pulse it latches up to three MicroBlaze-supplied note IDs (spreadsheet numbering) and converts each to a PWM period in clocks.
- It then plays the notes as an arpeggio, one at a time with silent gaps, followed by all notes together as a chord.
- Outputs are per-voice enables, periods and new_period strobes that feed freq_pwm directly, plus busy/done status.

Parameters:
- NOTE_TICKS, 50000000, cycles each arpeggio note sounds (0.5 s at 100 MHz); must be >= 1.
- GAP_TICKS, 5000000, silent cycles after each arpeggio note; 0 allowed, meaning no gap.
- CHORD_TICKS, 100000000, cycles the final chord sounds; must be >= 1.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin playback.
- abort  in  1  stop playback immediately.
- note_num  in  2  number of notes, 0..3.
- note_id_0  in  7  note 0 ID; note_id_1 and note_id_2 are identical 7-bit ports for notes 1 and 2.
- voice_en  out  3  bit k high while voice k must sound.
- voice_clks_0  out  32  voice 0 period in clocks; voice_clks_1 and voice_clks_2 are identical.
- new_period  out  3  one-cycle strobe per voice when its period register is loaded.
- busy  out  1  high while sequencing.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, CPU_RESETN low): state IDLE; all outputs 0, including all voice_clks, counters and latched IDs.
- ID to period conversion, per voice:
  - s = id - 4.
  - Valid IDs are 4..87 inclusive; any other ID gives period 0 and a muted voice.
  - pitch = s mod 12 (0 = C .. 11 = B); shift = (s div 12) + 1.
  - period = BASE[pitch] >> shift.
  - BASE table, C..B: 3057805, 2886184, 2724194, 2571298, 2426982, 2290765, 2162195, 2040840, 1926296, 1818182, 1716135, 1619816.
  - Division by 12 is implemented with a compare chain or LUT, not a divider.
- States: IDLE, ARP, GAP, CHORD.
  - Slot index k is 0..2.
  - A 32-bit tick counter is reloaded on every state entry.
- IDLE, on start sampled high with note_num = 0:
  - done = 1 on the next cycle.
  - busy stays 0; no voice activity.
- IDLE, on start sampled high with note_num >= 1, at that same edge:
  - Latch all IDs and compute periods into voice_clks_k for k < note_num; voice_clks_k = 0 for k >= note_num.
  - new_period[k] = 1 for exactly one cycle, for k < note_num.
  - busy = 1; enter ARP with k = 0.
- ARP: voice_en = one-hot bit k, ANDed with "voice k valid" (period != 0). Lasts exactly NOTE_TICKS cycles, then goes to GAP.
- GAP: voice_en = 0 for GAP_TICKS cycles, then:
  - k < note_num - 1: k increments, go to ARP.
  - Otherwise: go to CHORD.
  - If GAP_TICKS = 0, GAP is skipped and that transition is taken directly out of ARP.
- CHORD: voice_en[k] = 1 for every valid k < note_num, for exactly CHORD_TICKS cycles. Then go to IDLE, with done = 1 for one cycle and busy = 0 on the same edge.
- Total busy cycles = note_num * (NOTE_TICKS + GAP_TICKS) + CHORD_TICKS.
- Invalid voices still consume their ARP/GAP time slots, but their enable stays 0.
- start while busy is ignored.
- Input ID changes while busy are ignored; only the values latched at start are used.
- abort while busy: the next edge goes to IDLE with voice_en = 0 and busy = 0; no done pulse; voice_clks hold their values. abort while idle has no effect.
- start and abort in the same cycle:
  - Idle: start is taken and abort is ignored.
  - Busy: abort is taken.
- Reset asserted mid-sequence: all outputs go to 0 immediately (asynchronously); no done pulse.

Test Plan (NOTE_TICKS = 10, GAP_TICKS = 2, CHORD_TICKS = 20):
- Single note: note_num = 1, id0 = 28, start → voice_clks_0 = 382225 and new_period = 001 one cycle after start. voice_en = 001 for 10 cycles, then 000 for 2 cycles, then 001 for 20 cycles. done pulses; busy is high for exactly 32 cycles.
- Conversion corners:
  - id 39 → 202477.
  - id 87 → 12654 (1619816 >> 7).
  - id 4 → 1528902.
  - id 3 and id 88 → 0, with that voice never enabled.
- Three notes, ids 28/32/35: voice_en sequence is 001 (10), 000 (2), 010 (10), 000 (2), 100 (10), 000 (2), 111 (20), then done. busy lasts 56 cycles; id changes mid-sequence leave voice_clks unchanged.
- note_num = 0, start → done = 1 on the next cycle; busy, voice_en and new_period stay 0.
- Abort and restart: abort in the 5th ARP cycle of note 1 → voice_en = 0 and busy = 0 on the next edge, no done pulse. A new start is then accepted normally. A second start pulse issued while busy produces no effect.
- Async reset: CPU_RESETN low during CHORD → all outputs 0 without waiting for a clock edge. After release, the block is in IDLE and done never pulses.

Source files
------------

// File: rtl/et_chord_sequencer_if.sv
// Control/playback bundle between the MicroBlaze side and the chord sequencer.
// The master drives requests and note IDs; the slave (sequencer) drives voice controls.
interface et_chord_sequencer_if;
    logic        start;
    logic        abort;
    logic [1:0]  note_num;
    logic [6:0]  note_id_0;
    logic [6:0]  note_id_1;
    logic [6:0]  note_id_2;
    logic [2:0]  voice_en;
    logic [31:0] voice_clks_0;
    logic [31:0] voice_clks_1;
    logic [31:0] voice_clks_2;
    logic [2:0]  new_period;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, note_num, note_id_0, note_id_1, note_id_2,
        input  voice_en, voice_clks_0, voice_clks_1, voice_clks_2, new_period, busy, done
    );
    modport slave (
        input  start, abort, note_num, note_id_0, note_id_1, note_id_2,
        output voice_en, voice_clks_0, voice_clks_1, voice_clks_2, new_period, busy, done
    );
endinterface

// File: rtl/et_chord_sequencer.sv
// Ear-training playback: latches up to three note IDs, plays them as an
// arpeggio with silent gaps, then as a chord, driving freq_pwm voices directly.
module et_chord_sequencer #(
    parameter int unsigned NOTE_TICKS  = 50000000,
    parameter int unsigned GAP_TICKS   = 5000000,
    parameter int unsigned CHORD_TICKS = 100000000
) (
    input logic CLK100MHZ,
    input logic CPU_RESETN,
    et_chord_sequencer_if.slave bus
);
    localparam logic [31:0] NOTE_LD  = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LD   = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
    localparam logic [31:0] CHORD_LD = 32'(CHORD_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ARP, GAP, CHORD} state_t;

    // Spreadsheet note ID -> PWM period; octave found with a compare chain.
    function automatic logic [31:0] id_to_period(input logic [6:0] id);
        logic [6:0]  s;
        logic [3:0]  r;
        logic [2:0]  oct;
        logic [31:0] base;
        s = id - 7'd4;
        if      (s >= 7'd72) begin oct = 3'd6; r = 4'(s - 7'd72); end
        else if (s >= 7'd60) begin oct = 3'd5; r = 4'(s - 7'd60); end
        else if (s >= 7'd48) begin oct = 3'd4; r = 4'(s - 7'd48); end
        else if (s >= 7'd36) begin oct = 3'd3; r = 4'(s - 7'd36); end
        else if (s >= 7'd24) begin oct = 3'd2; r = 4'(s - 7'd24); end
        else if (s >= 7'd12) begin oct = 3'd1; r = 4'(s - 7'd12); end
        else                 begin oct = 3'd0; r = 4'(s); end
        case (r)
            4'd0:    base = 32'd3057805;
            4'd1:    base = 32'd2886184;
            4'd2:    base = 32'd2724194;
            4'd3:    base = 32'd2571298;
            4'd4:    base = 32'd2426982;
            4'd5:    base = 32'd2290765;
            4'd6:    base = 32'd2162195;
            4'd7:    base = 32'd2040840;
            4'd8:    base = 32'd1926296;
            4'd9:    base = 32'd1818182;
            4'd10:   base = 32'd1716135;
            4'd11:   base = 32'd1619816;
            default: base = 32'd0;
        endcase
        if (id < 7'd4 || id > 7'd87) id_to_period = 32'd0;
        else                         id_to_period = base >> (oct + 3'd1);
    endfunction

    state_t      state, state_d;
    logic [1:0]  k, k_d;
    logic [1:0]  num;
    logic [31:0] tick, tick_d;
    logic        load, done_d;
    logic [31:0] clks [3];
    logic [2:0]  valid, load_mask;
    logic [6:0]  ids [3];

    assign ids[0] = bus.note_id_0;
    assign ids[1] = bus.note_id_1;
    assign ids[2] = bus.note_id_2;

    for (genvar i = 0; i < 3; i++) begin : g_voice
        assign valid[i]     = (clks[i] != 32'd0);
        assign load_mask[i] = (2'(i) < bus.note_num);
    end

    always_comb begin
        state_d = state;
        k_d     = k;
        tick_d  = (tick == 32'd0) ? 32'd0 : tick - 32'd1;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.note_num == 2'd0) done_d = 1'b1;
                else begin
                    load    = 1'b1;
                    state_d = ARP;
                    k_d     = 2'd0;
                    tick_d  = NOTE_LD;
                end
            end
            ARP, GAP: begin
                if (bus.abort) state_d = IDLE;
                else if (tick == 32'd0) begin
                    if (state == ARP && GAP_TICKS != 0) begin
                        state_d = GAP;
                        tick_d  = GAP_LD;
                    end else if ({1'b0, k} + 3'd1 < {1'b0, num}) begin
                        state_d = ARP;
                        k_d     = k + 2'd1;
                        tick_d  = NOTE_LD;
                    end else begin
                        state_d = CHORD;
                        tick_d  = CHORD_LD;
                    end
                end
            end
            CHORD: begin
                if (bus.abort) state_d = IDLE;
                else if (tick == 32'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state          <= IDLE;
            k              <= 2'd0;
            num            <= 2'd0;
            tick           <= 32'd0;
            bus.done       <= 1'b0;
            bus.new_period <= 3'b000;
            for (int i = 0; i < 3; i++) clks[i] <= 32'd0;
        end else begin
            state          <= state_d;
            k              <= k_d;
            tick           <= tick_d;
            bus.done       <= done_d;
            bus.new_period <= load ? load_mask : 3'b000;
            if (load) begin
                num <= bus.note_num;
                for (int i = 0; i < 3; i++)
                    clks[i] <= load_mask[i] ? id_to_period(ids[i]) : 32'd0;
            end
        end
    end

    // Voices with a zero period stay muted but still use their time slot.
    always_comb begin
        bus.voice_en = 3'b000;
        case (state)
            ARP:     bus.voice_en = valid & (3'b001 << k);
            CHORD:   bus.voice_en = valid;
            default: bus.voice_en = 3'b000;
        endcase
    end

    assign bus.busy         = (state != IDLE);
    assign bus.voice_clks_0 = clks[0];
    assign bus.voice_clks_1 = clks[1];
    assign bus.voice_clks_2 = clks[2];
endmodule
